// File: rtl/pn_seq_stream.sv
// ============================================================================
// pn_seq_stream : Fibonacci-LFSR PN source, bipolar I/Q over a valid/ready stream
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module pn_seq_stream #(
  parameter int MAX_ORDER = 16,
  parameter int ORDER_W   = 5,
  parameter int SAMP_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [MAX_ORDER-1:0] i_poly,
  input  logic [MAX_ORDER-1:0] i_seed,
  input  logic [ORDER_W-1:0]   i_order,
  input  logic [CNT_W-1:0]     i_num_periods,
  input  logic [SAMP_W-1:0]    i_amp,
  output logic [2*SAMP_W-1:0]  o_tdata,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic                 o_tlast,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_ORDER-1:0] poly_q, poly_d;
  logic [MAX_ORDER-1:0] seed_q, seed_d;
  logic [MAX_ORDER-1:0] mask_q, mask_d;
  logic [MAX_ORDER-1:0] lfsr_q, lfsr_d;
  logic [MAX_ORDER-1:0] chip_cnt_q, chip_cnt_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
  logic [SAMP_W-1:0]    amp_q, amp_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [MAX_ORDER-1:0] w_mask_in;
  logic [MAX_ORDER-1:0] w_top_bit;
  logic [MAX_ORDER-1:0] w_lfsr_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_order_ok;
  logic                 w_seed_ok;
  logic                 w_fb;
  logic                 w_run;
  logic                 w_xfer;
  logic                 w_at_last;
  logic [SAMP_W-1:0]    w_i_samp;

  always_comb begin
    w_mask_in = '0;
    for (int k = 0; k < MAX_ORDER; k++) begin
      w_mask_in[k] = (k < int'(i_order));
    end
  end

  assign w_order_ok = (i_order >= ORDER_W'(2)) && (i_order <= ORDER_W'(MAX_ORDER));
  assign w_seed_ok  = |(i_seed & w_mask_in);

  // State bits above the order are always zero, so a plain right shift plus
  // feedback injected at bit N-1 is the full update.
  assign w_top_bit   = mask_q ^ (mask_q >> 1);
  assign w_fb        = ^(lfsr_q & poly_q & mask_q);
  assign w_lfsr_next = (lfsr_q >> 1) | ({MAX_ORDER{w_fb}} & w_top_bit);

  assign w_run     = (state_q == ST_RUN);
  assign w_xfer    = w_run & i_tready;
  assign w_at_last = (chip_cnt_q == (mask_q - MAX_ORDER'(1)));
  assign w_cnt_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    poly_d       = poly_q;
    seed_d       = seed_q;
    mask_d       = mask_q;
    lfsr_d       = lfsr_q;
    chip_cnt_d   = chip_cnt_q;
    num_d        = num_q;
    period_cnt_d = period_cnt_q;
    amp_d        = amp_q;
    stop_d       = stop_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (w_order_ok && w_seed_ok) begin
            poly_d       = i_poly;
            seed_d       = i_seed & w_mask_in;
            mask_d       = w_mask_in;
            lfsr_d       = i_seed & w_mask_in;
            chip_cnt_d   = '0;
            num_d        = i_num_periods;
            period_cnt_d = '0;
            amp_d        = i_amp;
            stop_d       = 1'b0;
            state_d      = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (i_stop) begin
          stop_d = 1'b1;
        end
        if (w_xfer) begin
          if (w_at_last) begin
            // Reloading the seed keeps every period identical even when the
            // polynomial is not maximal-length.
            chip_cnt_d   = '0;
            lfsr_d       = seed_q;
            period_cnt_d = w_cnt_inc;
            if (((num_q != '0) && (w_cnt_inc == num_q)) || stop_q || i_stop) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            chip_cnt_d = chip_cnt_q + MAX_ORDER'(1);
            lfsr_d     = w_lfsr_next;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      poly_q       <= '0;
      seed_q       <= '0;
      mask_q       <= '0;
      lfsr_q       <= '0;
      chip_cnt_q   <= '0;
      num_q        <= '0;
      period_cnt_q <= '0;
      amp_q        <= '0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      poly_q       <= poly_d;
      seed_q       <= seed_d;
      mask_q       <= mask_d;
      lfsr_q       <= lfsr_d;
      chip_cnt_q   <= chip_cnt_d;
      num_q        <= num_d;
      period_cnt_q <= period_cnt_d;
      amp_q        <= amp_d;
      stop_q       <= stop_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign w_i_samp  = lfsr_q[0] ? amp_q : (SAMP_W'(0) - amp_q);
  assign o_tdata   = w_run ? {w_i_samp, SAMP_W'(0)} : '0;
  assign o_tvalid  = w_run;
  assign o_tlast   = w_run & w_at_last;
  assign o_busy    = w_run;
  assign o_done    = done_q;
  assign o_cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pn_seq_stream.sv
// ============================================================================
// tb_pn_seq_stream : scoreboard bench for pn_seq_stream
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pn_seq_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_poly = '0;
  logic [15:0] i_seed = '0;
  logic [4:0]  i_order = '0;
  logic [15:0] i_num_periods = '0;
  logic [15:0] i_amp = '0;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        i_tready = 1'b1;
  logic        o_tlast;
  logic        o_busy;
  logic        o_done;
  logic        o_cfg_err;

  int          tests = 0;
  int          fails = 0;
  int          beat_cnt = 0;
  bit          ready_rand = 1'b0;
  logic [32:0] sb[$];

  pn_seq_stream #(
    .MAX_ORDER(16), .ORDER_W(5), .SAMP_W(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_poly(i_poly), .i_seed(i_seed), .i_order(i_order),
    .i_num_periods(i_num_periods), .i_amp(i_amp),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tlast(o_tlast), .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: a beat is committed when valid & ready are seen between edges.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] exp_beat;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!(o_tvalid === 1'b1 && o_tdata === prev_data && o_tlast === prev_last)) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   o_tvalid, o_tdata, o_tlast, prev_data, prev_last);
        end
      end
      if (o_tvalid === 1'b1 && i_tready === 1'b1) begin
        beat_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got beat %0d data=%h last=%b, want no beat",
                   beat_cnt, o_tdata, o_tlast);
        end else begin
          exp_beat = sb.pop_front();
          if ({o_tlast, o_tdata} !== exp_beat) begin
            fails++;
            $display("FAIL beat_%0d: got last=%b data=%h, want last=%b data=%h",
                     beat_cnt, o_tlast, o_tdata, exp_beat[32], exp_beat[31:0]);
          end
        end
      end
      prev_stall = (o_tvalid === 1'b1) && (i_tready === 1'b0);
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  end

  // Reference period for order 3, poly 011, seed 001: chips 1,0,0,1,0,1,1.
  task automatic push_table3(input logic [15:0] amp);
    logic [6:0] chips;
    chips = 7'b1001011;
    for (int i = 0; i < 7; i++) begin
      sb.push_back({(i == 6), (chips[6-i] ? amp : 16'(16'h0 - amp)), 16'h0000});
    end
  endtask

  // Independent Fibonacci model used for the longer sequences.
  task automatic push_model(input int order, input logic [15:0] poly,
                            input logic [15:0] seed, input logic [15:0] amp);
    logic [15:0] s, mask;
    logic        fb;
    int          len;
    len  = (1 << order) - 1;
    mask = 16'(len);
    s    = seed & mask;
    for (int i = 0; i < len; i++) begin
      sb.push_back({(i == len - 1), (s[0] ? amp : 16'(16'h0 - amp)), 16'h0000});
      fb = ^(s & poly & mask);
      s  = s >> 1;
      if (fb) s[order-1] = 1'b1;
    end
  endtask

  task automatic do_start(input logic [15:0] poly, input logic [15:0] seed,
                          input logic [4:0] order, input logic [15:0] nper,
                          input logic [15:0] amp);
    @(posedge clk);
    #1;
    i_start = 1'b1; i_poly = poly; i_seed = seed; i_order = order;
    i_num_periods = nper; i_amp = amp;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_poly = '0; i_seed = '0; i_order = '0; i_num_periods = '0; i_amp = '0;
  endtask

  // Returns at the first posedge+1 where beat_cnt has reached target.
  task automatic wait_beats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (beat_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_tvalid, o_tlast, o_busy, o_done, o_cfg_err, o_tdata} !== 37'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b e=%b data=%h, want all 0",
               o_tvalid, o_tlast, o_busy, o_done, o_cfg_err, o_tdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    beat_cnt = 0;
    push_table3(16'h4000);
    push_table3(16'h4000);
    do_start(16'h0003, 16'h0001, 5'd3, 16'd2, 16'h4000);
    tests++;
    if (o_tvalid !== 1'b1 || o_busy !== 1'b1 || o_tdata !== 32'h4000_0000) begin
      fails++;
      $display("FAIL basic_first: got v=%b b=%b data=%h, want v=1 b=1 data=40000000",
               o_tvalid, o_busy, o_tdata);
    end
    wait_beats(14, 100, ok);
    tests++;
    if (!ok || o_done !== 1'b1 || o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got ok=%b done=%b busy=%b valid=%b, want 1 1 0 0",
               ok, o_done, o_busy, o_tvalid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_done !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL basic_after: got done=%b left=%0d, want done=0 left=0", o_done, sb.size());
    end
  endtask

  task automatic test_back_to_back_stall;
    bit ok;
    beat_cnt   = 0;
    ready_rand = 1'b1;
    push_table3(16'h4000);
    push_table3(16'h4000);
    do_start(16'h0003, 16'h0001, 5'd3, 16'd2, 16'h4000);
    wait_beats(14, 400, ok);
    ready_rand = 1'b0;
    tests++;
    if (!ok || o_done !== 1'b1 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_done: got ok=%b done=%b busy=%b, want 1 1 0", ok, o_done, o_busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (beat_cnt != 14 || sb.size() != 0) begin
      fails++;
      $display("FAIL stall_count: got beats=%0d left=%0d, want 14 0", beat_cnt, sb.size());
    end
  endtask

  task automatic test_stop;
    bit ok;
    beat_cnt = 0;
    push_model(6, 16'h0003, 16'h0001, 16'h1234);
    do_start(16'h0003, 16'h0001, 5'd6, 16'd0, 16'h1234);
    wait_beats(20, 100, ok);
    tests++;
    if (!ok || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL stop_pre: got ok=%b busy=%b, want 1 1", ok, o_busy);
    end
    i_stop = 1'b1;
    @(posedge clk);
    #1;
    i_stop = 1'b0;
    wait_beats(63, 200, ok);
    tests++;
    if (!ok || o_done !== 1'b1 || o_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL stop_done: got ok=%b done=%b valid=%b, want 1 1 0", ok, o_done, o_tvalid);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (beat_cnt != 63 || sb.size() != 0) begin
      fails++;
      $display("FAIL stop_count: got beats=%0d left=%0d, want 63 0", beat_cnt, sb.size());
    end
  endtask

  task automatic test_reject;
    logic [4:0]  orders[3];
    logic [15:0] seeds[3];
    orders = '{5'd1, 5'd17, 5'd3};
    seeds  = '{16'h0001, 16'h0001, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      beat_cnt = 0;
      do_start(16'h0003, seeds[i], orders[i], 16'd1, 16'h4000);
      tests++;
      if (o_cfg_err !== 1'b1 || o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL reject_%0d: got err=%b valid=%b busy=%b, want 1 0 0",
                 i, o_cfg_err, o_tvalid, o_busy);
      end
      @(posedge clk);
      #1;
      tests++;
      if (o_cfg_err !== 1'b0 || o_tvalid !== 1'b0 || beat_cnt != 0) begin
        fails++;
        $display("FAIL reject_after_%0d: got err=%b valid=%b beats=%0d, want 0 0 0",
                 i, o_cfg_err, o_tvalid, beat_cnt);
      end
    end
  endtask

  task automatic test_long_order;
    bit ok;
    beat_cnt = 0;
    push_model(16, 16'h002D, 16'h0001, 16'h0100);
    sb.push_back({1'b0, 16'h0100, 16'h0000});
    do_start(16'h002D, 16'h0001, 5'd16, 16'd0, 16'h0100);
    wait_beats(65536, 70000, ok);
    rst = 1'b1;
    tests++;
    if (!ok || sb.size() != 0) begin
      fails++;
      $display("FAIL long_wrap: got ok=%b left=%0d, want 1 0", ok, sb.size());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tests++;
    if ({o_tvalid, o_tlast, o_busy, o_done} !== 4'b0) begin
      fails++;
      $display("FAIL long_reset: got v=%b l=%b b=%b d=%b, want all 0",
               o_tvalid, o_tlast, o_busy, o_done);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    beat_cnt = 0;
    push_table3(16'h7FFF);
    do_start(16'h0003, 16'h0001, 5'd3, 16'd1, 16'h7FFF);
    wait_beats(3, 50, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (!ok || {o_tvalid, o_tlast, o_busy, o_done, o_cfg_err, o_tdata} !== 37'h0) begin
      fails++;
      $display("FAIL mid_reset: got ok=%b v=%b l=%b b=%b d=%b data=%h, want ok=1 all 0",
               ok, o_tvalid, o_tlast, o_busy, o_done, o_tdata);
    end
    rst = 1'b0;
    sb.delete();
    beat_cnt = 0;
    push_table3(16'h7FFF);
    do_start(16'h0003, 16'h0001, 5'd3, 16'd1, 16'h7FFF);
    wait_beats(7, 50, ok);
    tests++;
    if (!ok || o_done !== 1'b1 || sb.size() != 0) begin
      fails++;
      $display("FAIL mid_restart: got ok=%b done=%b left=%0d, want 1 1 0", ok, o_done, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back_stall;
    test_stop;
    test_reject;
    test_reset_mid;
    test_long_order;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pn_seq_stream.md
Name: pn_seq_stream

Overview:
Parametrised PN-sequence source for the channel sounder TX path.
- Generates a maximal-length (or user-polynomial) Fibonacci LFSR sequence of run-time order 2..MAX_ORDER.
- Maps each chip to a bipolar I/Q sample and streams it over an AXI-stream style handshake with back-pressure.
- Marks each period end with tlast and runs either a programmed number of periods or continuously, then signals done.

Parameters:
MAX_ORDER, 16, maximum LFSR order and width of the poly/seed ports
ORDER_W, 5, width of i_order; must hold MAX_ORDER
SAMP_W, 16, width of each I and Q component
CNT_W, 16, width of the period counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; latches config and starts streaming when idle
i_stop  in  1  one-cycle pulse; requests a halt at the next period end
i_poly  in  MAX_ORDER  tap mask; bit k taps state bit s[k]
i_seed  in  MAX_ORDER  initial state; only bits [order-1:0] are used
i_order  in  ORDER_W  LFSR order N
i_num_periods  in  CNT_W  periods to emit; 0 = continuous
i_amp  in  SAMP_W  two's-complement amplitude
o_tdata  out  2*SAMP_W  {I, Q}; I = +amp for chip 1, -amp for chip 0; Q = 0
o_tvalid  out  1  sample valid
i_tready  in  1  downstream ready
o_tlast  out  1  high on the last chip of each period
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse on completion or stop
o_cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, and takes priority over everything.
- Reset values: state IDLE; o_tvalid, o_tlast, o_busy, o_done and o_cfg_err = 0; o_tdata = 0; all internal registers = 0.
- Config latch: on i_start in IDLE, latch poly, seed, order, num_periods and amp.
  - Reject the start if order < 2, order > MAX_ORDER, or (seed & mask(order)) == 0.
  - On reject: pulse o_cfg_err in the next cycle and stay IDLE.
  - i_start while in RUN is ignored. Config inputs are don't-care outside the start cycle.
- LFSR update: state s[MAX_ORDER-1:0], masked to the order.
  - chip = s[0]; fb = ^(s & poly & mask).
  - On advance: s[k] <= s[k+1] for k < N-1; s[N-1] <= fb; bits >= N stay 0.
- Period: chip counter runs 0..(2^N - 2). o_tlast is asserted when the counter equals 2^N - 2.
  - At the tlast handshake the counter wraps to 0 and s reloads the latched seed, so every period is bit-identical even for non-maximal polynomials.
- Handshake and latency:
  - First valid sample appears 1 cycle after an accepted start: o_tvalid = 1 with chip = seed[0].
  - A beat transfers when o_tvalid & i_tready. Only a transfer advances s and the counter.
  - o_tdata and o_tlast are held stable while o_tvalid & !i_tready.
  - In RUN, o_tvalid is never deasserted without a transfer.
- States:
  - IDLE: on a valid start, go to RUN.
  - RUN: on a tlast transfer, increment the period count. Go to IDLE with o_done pulsed the following cycle when (num_periods != 0 and count == num_periods) or a stop is pending. Otherwise continue.
- Stop: i_stop in RUN sets a sticky stop-pending flag, honoured at the next tlast transfer; the current period always completes. i_stop in IDLE is ignored. Simultaneous i_start and i_stop in IDLE: start wins and the stop is ignored.
- Period counter: saturates; with num_periods = 0 it never terminates except via stop.
- Amplitude: -amp is two's-complement negation. amp = most-negative value is not supported; output for that case is don't-care.
- Reset mid-stream: output drops within 1 cycle; no tlast, no done.

Test Plan:
- order=3, poly=3'b011, seed=3'b001, amp=0x4000, num_periods=2, tready=1 -> chips 1,0,0,1,0,1,1 repeated twice. I = 0x4000/0xC000, Q = 0. tlast on beats 7 and 14; o_done pulse 1 cycle after beat 14; o_busy falls with it.
- Same config, tready toggled pseudo-randomly -> identical 14-beat sequence. tdata/tlast stable while stalled; no extra or missing beats.
- order=6, poly=6'b000011, seed=1, num_periods=0 -> 63-beat period with tlast every 63 beats. i_stop at beat 20 -> stream ends at beat 63, then o_done.
- Rejected starts: order=1, order=MAX_ORDER+1, and seed=0 -> each gives an o_cfg_err pulse, o_tvalid stays 0, state stays IDLE.
- order=MAX_ORDER, maximal poly, seed=1 -> tlast exactly at beat 2^16 - 1 and the next beat restarts with chip seed[0].
- rst asserted mid-period with tready=1 -> all outputs 0 on the next cycle. A subsequent start reproduces the sequence from its first chip.
